// File: rtl/dec_scan_n.sv
// dec_scan_n: registered N-to-2^N one-hot decoder with active-low enable.
// Direct mode latches a select code and drives its one-hot output. With
// DEC_SCAN_N_SCAN_EN defined, scan mode steps the asserted output through every
// position and holds each one for DIV cycles. Without the macro, mode is ignored
// and wrap is tied to 0.
module dec_scan_n #(
    parameter int unsigned N    = 4,
    parameter int unsigned OUTS = 2 ** N,
    parameter int unsigned DIV  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Enable,
    input  logic            mode,
    input  logic            load,
    input  logic [N-1:0]    W,
    output logic [0:OUTS-1] Y,
    output logic [N-1:0]    idx,
    output logic            valid,
    output logic            wrap
);

    typedef enum logic [1:0] {
        StIdle,
        StDirect,
        StScan
    } state_e;

    state_e          r_state, w_state_next;
    logic [N-1:0]    r_idx, w_idx_next;
    logic [0:OUTS-1] r_y, w_y_next;
    logic            r_valid, w_valid_next;
    logic            r_wrap, w_wrap_next;

`ifdef DEC_SCAN_N_SCAN_EN
    localparam int unsigned  CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CntMax = CW'(DIV - 1);
    localparam logic [N-1:0]  IdxMax = {N{1'b1}};

    logic [CW-1:0] r_cnt, w_cnt_next;

    // Next state from the sampled enable and mode.
    always_comb begin
        w_state_next = StIdle;
        if (!Enable) begin
            w_state_next = mode ? StScan : StDirect;
        end
    end

    // Index/dwell update. Only cycles spent in StScan advance the dwell, so a
    // pause never shortens or stretches the time an output is visible.
    always_comb begin
        w_idx_next  = r_idx;
        w_cnt_next  = r_cnt;
        w_wrap_next = 1'b0;
        case (r_state)
            StIdle: begin
                if (load) w_idx_next = W;
            end
            StDirect: begin
                w_cnt_next = '0;
                if (load) w_idx_next = W;
            end
            StScan: begin
                if (load) begin
                    w_idx_next = W;
                    w_cnt_next = '0;
                end else if (r_cnt == CntMax) begin
                    w_cnt_next  = '0;
                    w_idx_next  = r_idx + 1'b1;
                    w_wrap_next = (r_idx == IdxMax);
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Dwell counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= w_cnt_next;
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = mode;

    // Next state: mode is ignored, any enabled cycle is direct.
    always_comb begin
        w_state_next = Enable ? StIdle : StDirect;
    end

    // Index update: load is honoured whether or not the decoder is enabled.
    always_comb begin
        w_idx_next  = load ? W : r_idx;
        w_wrap_next = 1'b0;
    end
`endif

    // Output decode from next-state values, so Y lines up with idx and state.
    always_comb begin
        w_y_next     = '0;
        w_valid_next = (w_state_next != StIdle);
        if (w_valid_next) w_y_next[w_idx_next] = 1'b1;
    end

    // State, index and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_y     <= w_y_next;
            r_valid <= w_valid_next;
            r_wrap  <= w_wrap_next;
        end
    end

    assign Y     = r_y;
    assign idx   = r_idx;
    assign valid = r_valid;
    assign wrap  = r_wrap;

endmodule
